morse_key_decoder: RTL and testbench

MORSE_KEY_DECODER -- requirements
Module: morse_key_decoder

---
 rtl/morse_key_decoder.sv | 130 +++++++++++++
 tb/tb_morse_key_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_decoder.sv
// morse_key_decoder: debounces a Morse key and decodes dot/dash timing into ASCII letters, digits and word spaces
module morse_key_decoder #(
  parameter int UNIT_CYCLES     = 6250000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Key,
  output logic       o_Key_Level,
  output logic       o_Char_DV,
  output logic [7:0] o_Char_Byte
);
  localparam logic [31:0] DOT_MAX = 32'(2 * UNIT_CYCLES);
  localparam logic [31:0] GAP_MAX = 32'(7 * UNIT_CYCLES);
  localparam logic [31:0] DB_MAX  = 32'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, KEY_DOWN, KEY_UP, LETTER_DONE} state_t;
  state_t      state, state_n;
  logic        sync_1, sync_2, ovf, clr, push, emit_l, emit_s;
  logic [31:0] db_cnt, cnt, cnt_inc;
  logic [4:0]  pat;
  logic [2:0]  len;
  logic [7:0]  letter;
  // A press landing on an emission cycle starts a fresh letter after the emission
  always_comb begin
    cnt_inc = (cnt == GAP_MAX) ? cnt : cnt + 32'd1;
    state_n = state;
    clr     = 1'b0;
    push    = 1'b0;
    emit_l  = 1'b0;
    emit_s  = 1'b0;
    case (state)
      IDLE: begin
        state_n = o_Key_Level ? KEY_DOWN : IDLE;
        clr     = o_Key_Level;
      end
      KEY_DOWN: begin
        state_n = o_Key_Level ? KEY_DOWN : KEY_UP;
        clr     = !o_Key_Level;
        push    = !o_Key_Level;
      end
      KEY_UP: begin
        emit_l  = cnt_inc == DOT_MAX;
        state_n = o_Key_Level ? KEY_DOWN : (emit_l ? LETTER_DONE : KEY_UP);
        clr     = o_Key_Level;
      end
      default: begin
        emit_s  = cnt_inc == GAP_MAX;
        state_n = o_Key_Level ? KEY_DOWN : (emit_s ? IDLE : LETTER_DONE);
        clr     = o_Key_Level;
      end
    endcase
  end
  // Pattern holds symbols in arrival order, first symbol most significant
  always_comb begin
    letter = 8'h3F;
    case ({len, pat})
      {3'd2, 5'b00001}: letter = "A";
      {3'd4, 5'b01000}: letter = "B";
      {3'd4, 5'b01010}: letter = "C";
      {3'd3, 5'b00100}: letter = "D";
      {3'd1, 5'b00000}: letter = "E";
      {3'd4, 5'b00010}: letter = "F";
      {3'd3, 5'b00110}: letter = "G";
      {3'd4, 5'b00000}: letter = "H";
      {3'd2, 5'b00000}: letter = "I";
      {3'd4, 5'b00111}: letter = "J";
      {3'd3, 5'b00101}: letter = "K";
      {3'd4, 5'b00100}: letter = "L";
      {3'd2, 5'b00011}: letter = "M";
      {3'd2, 5'b00010}: letter = "N";
      {3'd3, 5'b00111}: letter = "O";
      {3'd4, 5'b00110}: letter = "P";
      {3'd4, 5'b01101}: letter = "Q";
      {3'd3, 5'b00010}: letter = "R";
      {3'd3, 5'b00000}: letter = "S";
      {3'd1, 5'b00001}: letter = "T";
      {3'd3, 5'b00001}: letter = "U";
      {3'd4, 5'b00001}: letter = "V";
      {3'd3, 5'b00011}: letter = "W";
      {3'd4, 5'b01001}: letter = "X";
      {3'd4, 5'b01011}: letter = "Y";
      {3'd4, 5'b01100}: letter = "Z";
      {3'd5, 5'b11111}: letter = "0";
      {3'd5, 5'b01111}: letter = "1";
      {3'd5, 5'b00111}: letter = "2";
      {3'd5, 5'b00011}: letter = "3";
      {3'd5, 5'b00001}: letter = "4";
      {3'd5, 5'b00000}: letter = "5";
      {3'd5, 5'b10000}: letter = "6";
      {3'd5, 5'b11000}: letter = "7";
      {3'd5, 5'b11100}: letter = "8";
      {3'd5, 5'b11110}: letter = "9";
      default:          letter = 8'h3F;
    endcase
  end
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_1      <= 1'b0;
      sync_2      <= 1'b0;
      db_cnt      <= '0;
      o_Key_Level <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      pat         <= '0;
      len         <= '0;
      ovf         <= 1'b0;
      o_Char_DV   <= 1'b0;
      o_Char_Byte <= 8'h00;
    end else begin
      sync_1      <= i_Key;
      sync_2      <= sync_1;
      db_cnt      <= (sync_2 == o_Key_Level || db_cnt == DB_MAX) ? '0 : db_cnt + 32'd1;
      o_Key_Level <= (sync_2 != o_Key_Level && db_cnt == DB_MAX) ? sync_2 : o_Key_Level;
      state       <= state_n;
      cnt         <= clr ? '0 : cnt_inc;
      o_Char_DV   <= emit_l || emit_s;
      o_Char_Byte <= emit_l ? (ovf ? 8'h3F : letter) : (emit_s ? 8'h20 : o_Char_Byte);
      if (emit_l) begin
        pat <= '0;
        len <= '0;
        ovf <= 1'b0;
      end else if (push && len == 3'd5) begin
        ovf <= 1'b1;
      end else if (push) begin
        pat <= {pat[3:0], cnt >= DOT_MAX};
        len <= len + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_morse_key_decoder.sv
// tb_morse_key_decoder: drives keyed Morse traffic and checks decoded characters against a code-table model
module tb_morse_key_decoder;
  localparam int U  = 10;
  localparam int DB = 3;
  logic       i_Clock = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Key   = 1'b0;
  logic       o_Key_Level, o_Char_DV;
  logic [7:0] o_Char_Byte;
  int n_checks = 0, n_fail = 0, cyc = 0;
  byte unsigned got_q[$], exp_q[$];
  int got_t[$];
  bit dv_prev = 0, dbl = 0, lvl_seen = 0;
  string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
                        "...--", "....-", ".....", "-....", "--...", "---..", "----."};

  always #5 i_Clock = ~i_Clock;

  morse_key_decoder #(.UNIT_CYCLES(U), .DEBOUNCE_CYCLES(DB)) dut (
    .i_Clock(i_Clock), .i_Rst_L(i_Rst_L), .i_Key(i_Key),
    .o_Key_Level(o_Key_Level), .o_Char_DV(o_Char_DV), .o_Char_Byte(o_Char_Byte)
  );

  always @(negedge i_Clock) begin
    cyc++;
    if (o_Char_DV) begin
      got_q.push_back(o_Char_Byte);
      got_t.push_back(cyc);
    end
    if (o_Char_DV && dv_prev) dbl = 1;
    dv_prev = o_Char_DV;
    if (o_Key_Level) lvl_seen = 1;
  end

  function automatic byte unsigned ref_char(string s);
    for (int i = 0; i < 36; i++)
      if (codes[i] == s) return (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
    return 8'h3F;
  endfunction

  task automatic idle(int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic key_pulse(int on, int off);
    i_Key = 1;
    idle(on);
    i_Key = 0;
    idle(off);
  endtask

  task automatic send_letter(string s, int gap, bit rnd);
    for (int i = 0; i < s.len(); i++) begin
      int on, off;
      on  = (s[i] == 8'h2D) ? (rnd ? int'($urandom_range(32, 48)) : 40) : (rnd ? int'($urandom_range(8, 12)) : 10);
      off = (i == s.len() - 1) ? gap : (rnd ? int'($urandom_range(8, 12)) : 10);
      key_pulse(on, off);
    end
    exp_q.push_back(ref_char(s));
    if (gap > 7 * U) exp_q.push_back(8'h20);
  endtask

  task automatic start_test();
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    dbl = 0;
    lvl_seen = 0;
  endtask

  task automatic test_reset();
    idle(3);
    n_checks += 3;
    if (o_Key_Level !== 1'b0) begin n_fail++; $display("FAIL reset_level: got %b, expected 0", o_Key_Level); end
    if (o_Char_DV !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b, expected 0", o_Char_DV); end
    if (o_Char_Byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h, expected 00", o_Char_Byte); end
    i_Rst_L = 1;
    idle(5);
  endtask

  task automatic test_single_e();
    int rel;
    start_test();
    i_Key = 1;
    idle(10);
    i_Key = 0;
    rel = cyc;
    idle(100);
    exp_q.push_back(ref_char("."));
    exp_q.push_back(8'h20);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL e_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL e_char[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    if (got_t.size() >= 2) begin
      n_checks += 2;
      if (got_t[1] - got_t[0] !== 5 * U) begin n_fail++; $display("FAIL e_space_gap: got %0d cycles, expected %0d", got_t[1] - got_t[0], 5 * U); end
      if (got_t[0] - rel < 2 * U || got_t[0] - rel > 2 * U + 12) begin n_fail++; $display("FAIL e_latency: got %0d cycles, expected %0d..%0d", got_t[0] - rel, 2 * U, 2 * U + 12); end
    end
    n_checks += 2;
    if (lvl_seen !== 1'b1) begin n_fail++; $display("FAIL e_level_seen: got %b, expected 1", lvl_seen); end
    if (dbl !== 1'b0) begin n_fail++; $display("FAIL e_dv_double: got %b, expected 0", dbl); end
  endtask

  task automatic test_letter_c();
    start_test();
    send_letter("-.-.", 100, 0);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL c_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL c_char[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    start_test();
    send_letter("-----", 40, 0);
    send_letter("......", 40, 0);
    send_letter(".", 100, 0);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovf_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_char[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_glitch();
    start_test();
    repeat (10) key_pulse(2, 5);
    idle(100);
    n_checks += 2;
    if (lvl_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_level: got %b, expected 0", lvl_seen); end
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d, expected 0", got_q.size()); end
  endtask

  task automatic test_reset_mid_dash();
    start_test();
    i_Key = 1;
    idle(25);
    #2 i_Rst_L = 0;
    #1;
    n_checks += 4;
    if (lvl_seen !== 1'b1) begin n_fail++; $display("FAIL rst_pre_level: got %b, expected 1", lvl_seen); end
    if (o_Key_Level !== 1'b0) begin n_fail++; $display("FAIL rst_level: got %b, expected 0", o_Key_Level); end
    if (o_Char_DV !== 1'b0) begin n_fail++; $display("FAIL rst_dv: got %b, expected 0", o_Char_DV); end
    if (o_Char_Byte !== 8'h00) begin n_fail++; $display("FAIL rst_byte: got %h, expected 00", o_Char_Byte); end
    i_Key = 0;
    idle(3);
    i_Rst_L = 1;
    got_q.delete();
    idle(100);
    n_checks++;
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL rst_pulses: got %0d, expected 0", got_q.size()); end
    start_test();
    send_letter(".", 100, 0);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rst_recover_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_recover_char[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_saturation();
    start_test();
    send_letter(".", 500, 0);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL sat_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sat_char[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    start_test();
    for (int l = 0; l < 25; l++) begin
      string s;
      int n, gap;
      s = "";
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) s = {s, ($urandom_range(0, 1) == 1) ? "-" : "."};
      gap = (l == 24) ? 120 : (($urandom_range(0, 3) == 0) ? int'($urandom_range(90, 120)) : int'($urandom_range(35, 50)));
      send_letter(s, gap, 1);
    end
    n_checks += 2;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size()); end
    if (dbl !== 1'b0) begin n_fail++; $display("FAIL rand_dv_double: got %b, expected 0", dbl); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_char[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_e();
    test_letter_c();
    test_overflow();
    test_glitch();
    test_reset_mid_dash();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
